// File: rtl/mux_nto1_scan.sv
// N-to-1 sample multiplexer with registered output, valid/ready handshake,
// and an auto-scan mode that dwells on each channel for DWELL accepted samples.
module mux_nto1_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      sel_err
);

  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  localparam int DC_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W:0]   CH_LIM     = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
  localparam logic [DC_W-1:0]  LAST_DWELL = DC_W'(DWELL - 1);

  logic [0:0]       state;
  logic [SEL_W-1:0] scan_ptr;
  logic [DC_W-1:0]  dwell_cnt;

  logic             sel_bad;
  logic [SEL_W-1:0] sel_safe;
  logic [SEL_W-1:0] ptr;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sample;

  always_comb begin
    sel_bad  = ({1'b0, sel} >= CH_LIM);
    sel_safe = sel_bad ? '0 : sel;
    ptr      = (state == ST_SCAN) ? scan_ptr : sel_safe;
    load     = en & (~out_valid | out_ready);
    xfer     = out_valid & out_ready;
    sample   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ptr == SEL_W'(k)) sample = data_in[k*WIDTH +: WIDTH];
    end
  end

  // Pointer FSM: mode is sampled every clock, so a mode change is seen by the
  // load that follows the edge which updates state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_MANUAL;
      scan_ptr  <= '0;
      dwell_cnt <= '0;
      sel_err   <= 1'b0;
    end else begin
      state   <= mode ? ST_SCAN : ST_MANUAL;
      sel_err <= (state == ST_MANUAL) & sel_bad;
      if (state == ST_MANUAL) begin
        if (mode) begin
          scan_ptr  <= sel_safe;
          dwell_cnt <= '0;
        end
      end else if (!mode) begin
        dwell_cnt <= '0;
      end else if (load) begin
        // Scanning advances on accepted loads only, so a stall freezes it.
        if (dwell_cnt == LAST_DWELL) begin
          dwell_cnt <= '0;
          scan_ptr  <= (scan_ptr == LAST_CH) ? '0 : scan_ptr + 1'b1;
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= sample;
      out_ch    <= ptr;
      out_valid <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed bench for mux_nto1_scan: a 4-channel instance for the main paths
// and a 3-channel instance for out-of-range manual select.
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] data_in;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        sel_err;

  logic [1:0]  sel_b;
  logic [23:0] data_b;
  logic [7:0]  out_data_b;
  logic [1:0]  out_ch_b;
  logic        out_valid_b;
  logic        sel_err_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_nto1_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .data_in(data_in),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .sel_err(sel_err)
  );

  mux_nto1_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_b), .data_in(data_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_ch(out_ch_b),
    .out_valid(out_valid_b), .sel_err(sel_err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b0;
    data_in   = {8'h43, 8'hA5, 8'h21, 8'h10};
    sel_b     = 2'd0;
    data_b    = {8'hC2, 8'hB1, 8'hB0};
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_ch", {30'd0, out_ch}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    #10 rst = 1'b0;

    // Manual select of channel 2
    sel = 2'd2; en = 1'b1; out_ready = 1'b1;
    tick();
    chk("man_data", {24'd0, out_data}, 32'hA5);
    chk("man_ch", {30'd0, out_ch}, 32'd2);
    chk("man_valid", {31'd0, out_valid}, 32'd1);

    // en low: pending sample drains, then nothing new is loaded
    en = 1'b0;
    tick();
    chk("enlo_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("enlo_drain_data", {24'd0, out_data}, 32'hA5);
    data_in[23:16] = 8'h5A;
    tick();
    chk("enlo_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("enlo_idle_data", {24'd0, out_data}, 32'hA5);
    data_in[23:16] = 8'hA5;

    // Asynchronous reset mid-stream, checked between clock edges
    en = 1'b1;
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", {24'd0, out_data}, 32'd0);
    chk("arst_ch", {30'd0, out_ch}, 32'd0);
    #1 rst = 1'b0;

    // Scan: enter SCAN with en low so the first scan load starts on channel 0
    en = 1'b0; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    tick();
    en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      logic [1:0] exp_ch;
      logic [7:0] exp_d;
      exp_ch = 2'((k / 4) % 4);
      exp_d  = data_in[8*exp_ch +: 8];
      tick();
      chk($sformatf("scan_ch_%0d", k), {30'd0, out_ch}, {30'd0, exp_ch});
      chk($sformatf("scan_data_%0d", k), {24'd0, out_data}, {24'd0, exp_d});
      chk($sformatf("scan_valid_%0d", k), {31'd0, out_valid}, 32'd1);
    end

    // Backpressure: five stalled clocks freeze output and dwell count
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall_ch_%0d", k), {30'd0, out_ch}, 32'd0);
      chk($sformatf("stall_data_%0d", k), {24'd0, out_data}, 32'h10);
      chk($sformatf("stall_valid_%0d", k), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick(); chk("resume_ch_0", {30'd0, out_ch}, 32'd0);
    tick(); chk("resume_ch_1", {30'd0, out_ch}, 32'd0);
    tick(); chk("resume_ch_2", {30'd0, out_ch}, 32'd0);
    tick(); chk("resume_ch_3", {30'd0, out_ch}, 32'd1);
    chk("resume_data_3", {24'd0, out_data}, 32'h21);

    // Leave scan: first load still uses the scan pointer, then manual applies
    mode = 1'b0; sel = 2'd3; sel_b = 2'd3;
    tick();
    chk("exit_scan_ch", {30'd0, out_ch}, 32'd1);
    tick();
    chk("manual3_ch", {30'd0, out_ch}, 32'd3);
    chk("manual3_data", {24'd0, out_data}, 32'h43);
    chk("manual3_sel_err", {31'd0, sel_err}, 32'd0);

    // Out-of-range select on the 3-channel instance
    chk("bad_sel_ch", {30'd0, out_ch_b}, 32'd0);
    chk("bad_sel_data", {24'd0, out_data_b}, 32'hB0);
    chk("bad_sel_err", {31'd0, sel_err_b}, 32'd1);
    sel_b = 2'd1;
    tick();
    chk("good_sel_err", {31'd0, sel_err_b}, 32'd0);
    chk("good_sel_ch", {30'd0, out_ch_b}, 32'd1);
    chk("good_sel_data", {24'd0, out_data_b}, 32'hB1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
